// File: rtl/sdp_ram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sdp_ram_pkg
// Purpose  : Shared types and constants for the SDP BRAM read controller:
//            controller state encoding, output FIFO depth, BRAM read latency
//            and default BRAM geometry.
// Revision : 1.0  initial release
// ============================================================================
package sdp_ram_pkg;

    localparam int DEF_MEM_ADDR_WIDTH = 9;
    localparam int DEF_MEM_WORD_WIDTH = 64;

    // Output buffering behind the BRAM; the credit check is sized to this.
    localparam int RD_FIFO_DEPTH      = 2;

    // The BRAM has read enable tied high and no output register, so data for
    // the address presented in cycle N is visible on rd_data in cycle N+1.
    localparam int BRAM_RD_LATENCY    = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } rd_state_t;

endpackage
`default_nettype wire

// File: rtl/sdp_rd_skid_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sdp_rd_skid_fifo
// Purpose  : Two-entry FIFO of {last, data} between the BRAM read port and
//            the output stream. The head entry registers directly drive the
//            stream outputs, so data/last hold steady while stalled.
// Ports    : clk, rst         clock, asynchronous active-high reset
//            i_push, i_din, i_din_last   write side (one word per cycle)
//            i_pop            consume head entry (valid & ready)
//            o_valid, o_data, o_last     head entry / stream outputs
//            o_count          current occupancy (0..2)
// Revision : 1.0  initial release
// ============================================================================
module sdp_rd_skid_fifo
    import sdp_ram_pkg::*;
#(
    parameter int WORD_WIDTH = DEF_MEM_WORD_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_push,
    input  logic [WORD_WIDTH-1:0] i_din,
    input  logic                  i_din_last,
    input  logic                  i_pop,
    output logic                  o_valid,
    output logic [WORD_WIDTH-1:0] o_data,
    output logic                  o_last,
    output logic [1:0]            o_count
);

    logic [1:0]            r_count;
    logic [WORD_WIDTH-1:0] r_head_data;
    logic [WORD_WIDTH-1:0] r_tail_data;
    logic                  r_head_last;
    logic                  r_tail_last;
    logic                  w_pop;
    logic                  w_push;

    // Guards keep the structure consistent even if a caller misbehaves:
    // no pop from empty, no push into a full FIFO unless a pop frees a slot.
    assign w_pop  = i_pop && (r_count != 2'd0);
    assign w_push = i_push && ((r_count != 2'd2) || w_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count     <= 2'd0;
            r_head_data <= '0;
            r_tail_data <= '0;
            r_head_last <= 1'b0;
            r_tail_last <= 1'b0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_head_data <= i_din;
                        r_head_last <= i_din_last;
                    end else begin
                        r_tail_data <= i_din;
                        r_tail_last <= i_din_last;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    if (r_count == 2'd2) begin
                        r_head_data <= r_tail_data;
                        r_head_last <= r_tail_last;
                    end
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    // Occupancy unchanged; the new word lands behind whatever
                    // remains after the head leaves.
                    if (r_count == 2'd2) begin
                        r_head_data <= r_tail_data;
                        r_head_last <= r_tail_last;
                        r_tail_data <= i_din;
                        r_tail_last <= i_din_last;
                    end else begin
                        r_head_data <= i_din;
                        r_head_last <= i_din_last;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_valid = (r_count != 2'd0);
    assign o_data  = r_head_data;
    assign o_last  = r_head_last;
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/sdp_ram_rd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sdp_ram_rd_ctrl
// Purpose  : Burst read controller for the read port of a simple-dual-port
//            BRAM. Takes {start address, length} commands, drives the BRAM
//            read address one word per cycle under a credit check, absorbs
//            the one-cycle BRAM read latency and presents the words as a
//            valid/ready stream with last-beat marking.
// Config   : SDP_RD_CTRL_WRAP_EN defined   -> bursts wrap past the top
//                                             address, err tied low.
//            SDP_RD_CTRL_WRAP_EN undefined -> bursts that would cross the
//                                             top address are truncated and
//                                             err pulses one cycle.
// Ports    : clk, rst                  clock, asynchronous active-high reset
//            cmd_valid/ready/addr/len  burst command handshake
//            mem_rd_addr, mem_rd_data  BRAM read port
//            m_valid/ready/data/last   output word stream
//            busy, done, err           status (done/err are 1-cycle pulses)
// Revision : 1.0  initial release
// ============================================================================
module sdp_ram_rd_ctrl
    import sdp_ram_pkg::*;
#(
    parameter int MEM_ADDR_WIDTH = DEF_MEM_ADDR_WIDTH,
    parameter int MEM_WORD_WIDTH = DEF_MEM_WORD_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [MEM_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [MEM_ADDR_WIDTH:0]   cmd_len,
    output logic [MEM_ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [MEM_WORD_WIDTH-1:0] mem_rd_data,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [MEM_WORD_WIDTH-1:0] m_data,
    output logic                      m_last,
    output logic                      busy,
    output logic                      done,
    output logic                      err
);

    rd_state_t                 r_state;
    rd_state_t                 w_state_nxt;
    logic [MEM_ADDR_WIDTH-1:0] r_addr;
    logic [MEM_ADDR_WIDTH:0]   r_remaining;
    logic                      r_inflight;
    logic                      r_inflight_last;
    logic                      r_err;

    logic [MEM_ADDR_WIDTH:0]   w_eff_len;
    logic                      w_trunc;
    logic                      w_accept;
    logic                      w_pop;
    logic [1:0]                w_fifo_count;
    logic [2:0]                w_occupancy;
    logic                      w_credit;
    logic                      w_issue;
    logic                      w_issue_last;
    logic                      w_drain_done;

    // ------------------------------------------------------------------
    // Effective burst length
    // ------------------------------------------------------------------
`ifdef SDP_RD_CTRL_WRAP_EN
    assign w_eff_len = cmd_len;
    assign w_trunc   = 1'b0;
`else
    localparam logic [MEM_ADDR_WIDTH+1:0] c_DEPTH =
        (MEM_ADDR_WIDTH+2)'(1) << MEM_ADDR_WIDTH;

    logic [MEM_ADDR_WIDTH+1:0] w_end;
    logic [MEM_ADDR_WIDTH:0]   w_room;

    // One extra bit on the sum so addr + len never aliases below the depth.
    assign w_end     = {2'b00, cmd_addr} + {1'b0, cmd_len};
    assign w_room    = c_DEPTH[MEM_ADDR_WIDTH:0] - {1'b0, cmd_addr};
    assign w_trunc   = (w_end > c_DEPTH);
    assign w_eff_len = w_trunc ? w_room : cmd_len;
`endif

    // ------------------------------------------------------------------
    // Handshakes and issue credit
    // ------------------------------------------------------------------
    assign cmd_ready = (r_state == IDLE) && !rst;
    assign w_accept  = cmd_valid && cmd_ready;
    assign w_pop     = m_valid && m_ready;

    // Words owed to the FIFO (buffered + the one in the BRAM pipeline),
    // net of the word leaving this cycle. Issuing only below the depth means
    // a word arriving next cycle always finds a free slot.
    assign w_occupancy  = 3'(w_fifo_count) + 3'(r_inflight) - 3'(w_pop);
    assign w_credit     = (w_occupancy < 3'(RD_FIFO_DEPTH));
    assign w_issue      = (r_state == RUN) && (r_remaining != '0) && w_credit;
    assign w_issue_last = w_issue && (r_remaining == (MEM_ADDR_WIDTH+1)'(1));

    // The last-tagged word is always the final one, so its handshake with
    // nothing left in flight means the FIFO is about to be empty.
    assign w_drain_done = !r_inflight && w_pop && m_last;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = (w_eff_len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (w_issue_last) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (w_drain_done) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Address / count / BRAM pipeline tracking
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr          <= '0;
            r_remaining     <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_err           <= 1'b0;
        end else begin
            r_err           <= w_accept && w_trunc;
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue_last;
            if (w_accept) begin
                r_addr      <= cmd_addr;
                r_remaining <= w_eff_len;
            end else if (w_issue) begin
                // Natural overflow of r_addr gives the modulo-depth wrap.
                r_addr      <= r_addr + 1'b1;
                r_remaining <= r_remaining - 1'b1;
            end
        end
    end

    assign mem_rd_addr = r_addr;

    // ------------------------------------------------------------------
    // Output FIFO: captures the BRAM word one cycle after its issue
    // ------------------------------------------------------------------
    sdp_rd_skid_fifo #(
        .WORD_WIDTH (MEM_WORD_WIDTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (r_inflight),
        .i_din      (mem_rd_data),
        .i_din_last (r_inflight_last),
        .i_pop      (w_pop),
        .o_valid    (m_valid),
        .o_data     (m_data),
        .o_last     (m_last),
        .o_count    (w_fifo_count)
    );

    assign busy = (r_state != IDLE);
    assign done = (r_state == DONE);
    assign err  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_sdp_ram_rd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdp_ram_rd_ctrl
// Purpose  : Self-checking bench for sdp_ram_rd_ctrl. A behavioural BRAM
//            (word i holds value i, one-cycle read latency) feeds the DUT.
//            Burst vectors with hand-computed lengths and completion cycles
//            are applied from a table; back-to-back commands and reset in
//            the middle of a burst are hand-written sequences.
//            Honours SDP_RD_CTRL_WRAP_EN in the same way as the design.
// Revision : 1.0  initial release
// ============================================================================
module tb_sdp_ram_rd_ctrl;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [8:0]  cmd_addr;
    logic [9:0]  cmd_len;
    logic [8:0]  mem_rd_addr;
    logic [63:0] mem_rd_data;
    logic        m_valid;
    logic        m_ready;
    logic [63:0] m_data;
    logic        m_last;
    logic        busy;
    logic        done;
    logic        err;

    int n_checks = 0;
    int n_err    = 0;

    logic [63:0] bram [512];

    typedef struct {
        logic [8:0] addr;
        logic [9:0] len;
        logic [7:0] pat;     // m_ready in cycle c = pat[c % period]
        int         period;
        int         len_w;   // expected beats, wrap build
        int         done_w;  // expected done cycle, wrap build
        int         len_t;   // expected beats, truncating build
        logic       err_t;   // expected err pulse, truncating build
        int         done_t;  // expected done cycle, truncating build
    } vec_t;

    vec_t vecs [7];
    vec_t v_single;

    sdp_ram_rd_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_addr    (cmd_addr),
        .cmd_len     (cmd_len),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .m_last      (m_last),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 512; i++) bram[i] = 64'(i);
    end

    always @(posedge clk) mem_rd_data <= bram[mem_rd_addr];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic run_burst(input vec_t v);
        int exp_len, exp_done, cyc, beats, issued, popped, max_out;
        int last_hs, first_v, done_cyc, err_other;
        logic err_exp, stall, held_l;
        logic [63:0] held_d;
        logic [8:0] prev_addr, wexp;
`ifdef SDP_RD_CTRL_WRAP_EN
        exp_len  = v.len_w;
        exp_done = v.done_w;
        err_exp  = 1'b0;
`else
        exp_len  = v.len_t;
        exp_done = v.done_t;
        err_exp  = v.err_t;
`endif
        chk("cmd_ready_idle", 64'(cmd_ready), 64'd1);
        cmd_addr  = v.addr;
        cmd_len   = v.len;
        cmd_valid = 1'b1;
        m_ready   = v.pat[0];
        tick();
        cmd_valid = 1'b0;
        cyc = 1;
        chk("rd_addr_c1", 64'(mem_rd_addr), 64'(v.addr));
        chk("err_c1", 64'(err), 64'(err_exp));
        chk("cmd_ready_c1", 64'(cmd_ready), 64'd0);
        chk("busy_c1", 64'(busy), 64'd1);
        beats = 0; issued = 0; popped = 0; max_out = 0;
        last_hs = -1; first_v = -1; done_cyc = -1; err_other = 0;
        stall = 1'b0; held_d = '0; held_l = 1'b0;
        prev_addr = mem_rd_addr;
        while (done_cyc < 0 && cyc < 300) begin
            m_ready = v.pat[cyc % v.period];
            if (cyc > 1 && mem_rd_addr != prev_addr) issued++;
            prev_addr = mem_rd_addr;
            if (issued - popped > max_out) max_out = issued - popped;
            if (cyc > 1 && err) err_other++;
            if (stall) begin
                chk("stall_valid", 64'(m_valid), 64'd1);
                chk("stall_data", m_data, held_d);
                chk("stall_last", 64'(m_last), 64'(held_l));
            end
            if (m_valid && first_v < 0) first_v = cyc;
            if (done) begin
                done_cyc = cyc;
                chk("valid_at_done", 64'(m_valid), 64'd0);
            end else if (m_valid && m_ready) begin
                wexp = v.addr + 9'(beats);
                chk("beat_data", m_data, {55'd0, wexp});
                chk("beat_last", 64'(m_last), 64'(beats == exp_len - 1));
                if (m_last) last_hs = cyc;
                beats++;
                popped++;
            end
            stall  = m_valid && !m_ready;
            held_d = m_data;
            held_l = m_last;
            if (done_cyc < 0) begin
                tick();
                cyc++;
            end
        end
        chk("done_seen", 64'(done_cyc >= 0), 64'd1);
        chk("beat_count", 64'(beats), 64'(exp_len));
        chk("issue_count", 64'(issued), 64'(exp_len));
        chk("outstanding_le_2", 64'(max_out <= 2), 64'd1);
        chk("done_cycle", 64'(done_cyc), 64'(exp_done));
        chk("err_not_repeated", 64'(err_other), 64'd0);
        if (exp_len > 0) chk("done_after_last", 64'(done_cyc), 64'(last_hs + 1));
        else             chk("len0_no_valid", 64'(first_v), 64'(-1));
        if (exp_len > 0 && v.period == 1) chk("first_valid_c3", 64'(first_v), 64'd3);
        tick();
        chk("cmd_ready_after_done", 64'(cmd_ready), 64'd1);
        chk("done_one_cycle", 64'(done), 64'd0);
        chk("busy_after_done", 64'(busy), 64'd0);
    endtask

    int          cyc;
    int          acc2;
    int          done1;
    int          done2;
    int          ndone;
    int          done_glitch;
    logic [64:0] got [$];
    logic [64:0] exp_b2b [5];

    initial begin : main
        //          addr     len    pat    per len_w done_w len_t err_t done_t
        vecs[0] = '{9'd10,  10'd4,  8'h01, 1,  4,    7,     4,    1'b0, 7};
        vecs[1] = '{9'd0,   10'd16, 8'h29, 6,  16,   34,    16,   1'b0, 34};
        vecs[2] = '{9'd510, 10'd4,  8'h01, 1,  4,    7,     2,    1'b1, 5};
        vecs[3] = '{9'd5,   10'd0,  8'h01, 1,  0,    1,     0,    1'b0, 1};
        vecs[4] = '{9'd500, 10'd12, 8'h01, 1,  12,   15,    12,   1'b0, 15};
        vecs[5] = '{9'd511, 10'd1,  8'h01, 1,  1,    4,     1,    1'b0, 4};
        vecs[6] = '{9'd200, 10'd3,  8'h04, 3,  3,    12,    3,    1'b0, 12};
        v_single = '{9'd0,  10'd1,  8'h01, 1,  1,    4,     1,    1'b0, 4};

        rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; m_ready = 1'b0;
        tick();
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        tick();
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("rst_cmd_ready_rel", 64'(cmd_ready), 64'd1);
        chk("rst_rd_addr", 64'(mem_rd_addr), 64'd0);
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_m_data", m_data, 64'd0);
        chk("rst_m_last", 64'(m_last), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);

        for (int i = 0; i < 7; i++) run_burst(vecs[i]);

        // Back-to-back: second command held valid from the first accept on.
        exp_b2b[0] = {1'b0, 64'd20};
        exp_b2b[1] = {1'b0, 64'd21};
        exp_b2b[2] = {1'b1, 64'd22};
        exp_b2b[3] = {1'b0, 64'd40};
        exp_b2b[4] = {1'b1, 64'd41};
        got.delete();
        cmd_addr = 9'd20; cmd_len = 10'd3; cmd_valid = 1'b1; m_ready = 1'b1;
        tick();
        cmd_addr = 9'd40; cmd_len = 10'd2;
        cyc = 1; acc2 = -1; done1 = -1; done2 = -1; ndone = 0;
        while (ndone < 2 && cyc < 60) begin
            if (cmd_valid && cmd_ready && acc2 < 0) acc2 = cyc;
            if (done) begin
                if (ndone == 0) done1 = cyc; else done2 = cyc;
                ndone++;
            end
            if (m_valid && m_ready) got.push_back({m_last, m_data});
            if (cyc == 8) chk("b2b_rd_addr_2nd", 64'(mem_rd_addr), 64'd40);
            tick();
            cyc++;
            if (acc2 >= 0) cmd_valid = 1'b0;
        end
        cmd_valid = 1'b0;
        chk("b2b_accept2_cycle", 64'(acc2), 64'd7);
        chk("b2b_done1_cycle", 64'(done1), 64'd6);
        chk("b2b_done2_cycle", 64'(done2), 64'd12);
        chk("b2b_beats", 64'(got.size()), 64'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < got.size()) begin
                chk("b2b_data", got[i][63:0], exp_b2b[i][63:0]);
                chk("b2b_last", 64'(got[i][64]), 64'(exp_b2b[i][64]));
            end
        end
        tick();

        // Reset in the middle of a burst.
        chk("midrst_cmd_ready", 64'(cmd_ready), 64'd1);
        cmd_addr = 9'd100; cmd_len = 10'd8; cmd_valid = 1'b1; m_ready = 1'b1;
        tick();
        cmd_valid = 1'b0;
        repeat (3) tick();
        chk("midrst_valid_before", 64'(m_valid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_valid_now", 64'(m_valid), 64'd0);
        chk("midrst_busy_now", 64'(busy), 64'd0);
        chk("midrst_rd_addr_now", 64'(mem_rd_addr), 64'd0);
        chk("midrst_cmd_ready_now", 64'(cmd_ready), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        done_glitch = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (done || m_valid) done_glitch++;
        end
        chk("midrst_no_done_no_valid", 64'(done_glitch), 64'd0);
        run_burst(v_single);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
